// File: rtl/spi_tx_frame_arbiter.sv
// Round-robin, frame-atomic arbiter sharing one SPI TX byte buffer among NUM_REQ byte streams.
// Optional macro SPI_TX_ARB_PRIO0_EN gives requester 0 strict priority at frame boundaries.
module spi_tx_frame_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic                 sysClk,
  input  logic                 sysRst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_byte,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           byte_out,
  output logic                 byte_out_valid,
  input  logic                 byte_out_ready,
  output logic                 frame_done,
  output logic                 frame_abort
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   last_owner_q;
  logic [7:0]         byte_q;
  logic               bvalid_q;
  logic               done_q;
  logic               abort_q;
  logic [CNT_W-1:0]   wdog_q;

  logic [NUM_REQ-1:0][7:0] masked_byte;
  logic [7:0]              owner_byte;
  logic                    owner_valid;
  logic                    owner_last;
  logic                    out_free;
  logic                    owner_accept;
  logic                    wdog_expire;

  logic [NUM_REQ-1:0] cand_valid;
  logic [IDX_W:0]     rr_pos;
  logic               rr_found;
  logic [IDX_W-1:0]   rr_idx;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;

  // Owner byte is selected by AND-masking with the one-hot grant, then OR-reducing.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign masked_byte[gi] = req_byte[8*gi +: 8] & {8{grant_q[gi]}};
    end
  endgenerate

  always_comb begin
    owner_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_byte = owner_byte | masked_byte[i];
    end
  end

  assign owner_valid  = |(req_valid & grant_q);
  assign owner_last   = |(req_last & grant_q);
  assign out_free     = ~bvalid_q | byte_out_ready;
  assign owner_accept = (state_q == ST_STREAM) & owner_valid & out_free;
  assign wdog_expire  = (state_q == ST_STREAM) & ~owner_valid &
                        (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));

  assign req_ready = (state_q == ST_STREAM && out_free) ? grant_q : '0;

  // Search last_owner+1, +2, ... with wrap; the first valid candidate wins.
  always_comb begin
`ifdef SPI_TX_ARB_PRIO0_EN
    cand_valid = {req_valid[NUM_REQ-1:1], 1'b0};
`else
    cand_valid = req_valid;
`endif
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_pos   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_pos = {1'b0, last_owner_q} + (IDX_W + 1)'(k);
      if (rr_pos >= (IDX_W + 1)'(NUM_REQ)) begin
        rr_pos = rr_pos - (IDX_W + 1)'(NUM_REQ);
      end
      if (!rr_found && cand_valid[rr_pos[IDX_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_pos[IDX_W-1:0];
      end
    end
    pick_valid = rr_found;
    pick_idx   = rr_idx;
`ifdef SPI_TX_ARB_PRIO0_EN
    if (req_valid[0]) begin
      pick_valid = 1'b1;
      pick_idx   = '0;
    end
`endif
  end

  assign pick_onehot = {{(NUM_REQ - 1){1'b0}}, 1'b1} << pick_idx;

  always_ff @(posedge sysClk or posedge sysRst) begin
    if (sysRst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      byte_q       <= 8'h00;
      bvalid_q     <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
      wdog_q       <= '0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;

      if (owner_accept) begin
        byte_q   <= owner_byte;
        bvalid_q <= 1'b1;
      end else if (byte_out_ready) begin
        bvalid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          wdog_q <= '0;
          if (pick_valid) begin
            grant_q <= pick_onehot;
            owner_q <= pick_idx;
            state_q <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          // An accepted byte always wins over a watchdog expiry in the same cycle.
          if (owner_accept) begin
            wdog_q <= '0;
            if (owner_last) begin
              done_q       <= 1'b1;
              last_owner_q <= owner_q;
              grant_q      <= '0;
              state_q      <= ST_IDLE;
            end
          end else if (wdog_expire) begin
            abort_q      <= 1'b1;
            last_owner_q <= owner_q;
            grant_q      <= '0;
            wdog_q       <= '0;
            state_q      <= ST_IDLE;
          end else if (!owner_valid) begin
            wdog_q <= wdog_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant          = grant_q;
  assign byte_out       = byte_q;
  assign byte_out_valid = bvalid_q;
  assign frame_done     = done_q;
  assign frame_abort    = abort_q;

endmodule

// File: tb/tb_spi_tx_frame_arbiter.sv
// Directed bench for spi_tx_frame_arbiter: each requester emits base + ptr*step, last every len bytes.
module tb_spi_tx_frame_arbiter;

  logic        sysClk = 1'b0;
  logic        sysRst = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [23:0] req_byte = '0;
  logic [2:0]  req_last = '0;
  logic [2:0]  req_ready;
  logic [2:0]  grant;
  logic [7:0]  byte_out;
  logic        byte_out_valid;
  logic        byte_out_ready = 1'b1;
  logic        frame_done;
  logic        frame_abort;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] base [3];
  logic [7:0] step [3];
  int         len  [3];
  int         ptr  [3];

  spi_tx_frame_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .sysClk(sysClk), .sysRst(sysRst),
    .req_valid(req_valid), .req_byte(req_byte), .req_last(req_last), .req_ready(req_ready),
    .grant(grant), .byte_out(byte_out), .byte_out_valid(byte_out_valid),
    .byte_out_ready(byte_out_ready), .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 sysClk = ~sysClk;

  task automatic apply();
    for (int i = 0; i < 3; i++) begin
      req_byte[8*i +: 8] = base[i] + 8'(ptr[i]) * step[i];
      req_last[i]        = ((ptr[i] % len[i]) == len[i] - 1);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; requesters whose byte was taken at the edge move to their next byte.
  task automatic tick();
    logic [2:0] acc;
    #1;
    acc = req_valid & req_ready;
    @(posedge sysClk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) ptr[i]++;
    end
    apply();
  endtask

  task automatic setup(input int i, input logic [7:0] b, input logic [7:0] s, input int l);
    base[i] = b;
    step[i] = s;
    len[i]  = l;
    ptr[i]  = 0;
    apply();
  endtask

  initial begin
    logic [2:0] exp_g;
    logic [7:0] exp_b;
    for (int i = 0; i < 3; i++) setup(i, 8'h00, 8'h01, 1);

    // Reset state
    @(posedge sysClk); @(posedge sysClk); #1;
    check("rst_grant", grant, 3'b000);
    check("rst_ready", req_ready, 3'b000);
    check("rst_bov", byte_out_valid, 1'b0);
    check("rst_byte", byte_out, 8'h00);
    check("rst_done", frame_done, 1'b0);
    check("rst_abort", frame_abort, 1'b0);
    sysRst = 1'b0;

    // Single 4-byte frame from req0
    setup(0, 8'hA1, 8'h11, 4);
    req_valid = 3'b001;
    tick();
    check("t1_grant", grant, 3'b001);
    check("t1_ready", req_ready, 3'b001);
    check("t1_bov0", byte_out_valid, 1'b0);
    tick(); check("t1_A1", byte_out, 8'hA1); check("t1_bov1", byte_out_valid, 1'b1);
    tick(); check("t1_B2", byte_out, 8'hB2); check("t1_nodone", frame_done, 1'b0);
    tick(); check("t1_C3", byte_out, 8'hC3);
    tick();
    check("t1_D4", byte_out, 8'hD4);
    check("t1_done", frame_done, 1'b1);
    check("t1_grant_end", grant, 3'b000);
    req_valid = 3'b000;
    tick();
    check("t1_done_pulse", frame_done, 1'b0);
    check("t1_drain", byte_out_valid, 1'b0);

    // Back-pressure mid-frame on req1
    setup(1, 8'h51, 8'h01, 4);
    req_valid = 3'b010;
    tick(); check("bp_grant", grant, 3'b010);
    tick(); check("bp_51", byte_out, 8'h51);
    byte_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold", byte_out, 8'h51);
      check("bp_ready0", req_ready, 3'b000);
      check("bp_noabort", frame_abort, 1'b0);
    end
    byte_out_ready = 1'b1;
    tick(); check("bp_52", byte_out, 8'h52); check("bp_ready1", req_ready, 3'b010);
    tick(); check("bp_53", byte_out, 8'h53);
    tick(); check("bp_54", byte_out, 8'h54); check("bp_done", frame_done, 1'b1);
    req_valid = 3'b000;

    // Stall: req1 sends one byte, then goes quiet; req0 and req2 wait
    setup(1, 8'h55, 8'h01, 4);
    req_valid = 3'b010;
    tick(); check("st_grant", grant, 3'b010);
    tick(); check("st_55", byte_out, 8'h55);
    req_valid = 3'b101;
    for (int c = 0; c < 63; c++) tick();
    check("st_63_noabort", frame_abort, 1'b0);
    check("st_63_grant", grant, 3'b010);
    check("st_drained", byte_out_valid, 1'b0);
    tick();
    check("st_abort", frame_abort, 1'b1);
    check("st_abort_grant", grant, 3'b000);
    check("st_abort_nodone", frame_done, 1'b0);
    tick();
    check("st_abort_pulse", frame_abort, 1'b0);
    check("st_next_req2", grant, 3'b100);

    // Byte arriving on the expiry cycle cancels the abort
    setup(2, 8'h70, 8'h01, 2);
    req_valid = 3'b001;
    for (int c = 0; c < 63; c++) tick();
    check("ex_grant", grant, 3'b100);
    req_valid = 3'b101;
    tick();
    check("ex_noabort", frame_abort, 1'b0);
    check("ex_70", byte_out, 8'h70);
    check("ex_grant_kept", grant, 3'b100);
    tick(); check("ex_71", byte_out, 8'h71); check("ex_done", frame_done, 1'b1);
    tick(); check("ex_next_req0", grant, 3'b001);

    // Asynchronous reset while a byte is held
    setup(0, 8'h90, 8'h01, 4);
    tick(); check("ar_90", byte_out, 8'h90); check("ar_bov", byte_out_valid, 1'b1);
    byte_out_ready = 1'b0;
    req_valid = 3'b000;
    #2 sysRst = 1'b1;
    #1;
    check("ar_bov_clr", byte_out_valid, 1'b0);
    check("ar_grant_clr", grant, 3'b000);
    check("ar_byte_clr", byte_out, 8'h00);
    @(posedge sysClk); #1;
    sysRst = 1'b0;
    byte_out_ready = 1'b1;

    // All three requesters continuously valid with 2-byte frames
    setup(0, 8'h10, 8'h01, 2);
    setup(1, 8'h20, 8'h01, 2);
    setup(2, 8'h30, 8'h01, 2);
    req_valid = 3'b111;
    tick(); check("rr_g0", grant, 3'b001);
    tick(); check("rr_10", byte_out, 8'h10);
    tick(); check("rr_11", byte_out, 8'h11); check("rr_done0", frame_done, 1'b1);
    tick(); check("rr_g1", grant, 3'b010); check("rr_gap", byte_out_valid, 1'b0);
    tick(); check("rr_20", byte_out, 8'h20);
    tick(); check("rr_21", byte_out, 8'h21); check("rr_done1", frame_done, 1'b1);
    tick(); check("rr_g2", grant, 3'b100);
    tick(); check("rr_30", byte_out, 8'h30);
    tick(); check("rr_31", byte_out, 8'h31); check("rr_done2", frame_done, 1'b1);
    tick(); check("rr_g0b", grant, 3'b001);
    tick(); check("rr_12", byte_out, 8'h12);
    tick(); check("rr_13", byte_out, 8'h13); check("rr_done0b", frame_done, 1'b1);

    // req0 and req2 contend right after req0's frame
`ifdef SPI_TX_ARB_PRIO0_EN
    exp_g = 3'b001; exp_b = 8'h14;
`else
    exp_g = 3'b100; exp_b = 8'h32;
`endif
    req_valid = 3'b101;
    tick(); check("pr_grant", grant, exp_g);
    tick(); check("pr_byte", byte_out, exp_b);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_tx_frame_arbiter.md
Name: spi_tx_frame_arbiter

Overview:
- Shares the single SPI transmit byte buffer among NUM_REQ byte-stream requesters: register-read serializer, telemetry stream, error/status reporter.
- Grants are round-robin and frame-atomic. Once a requester is granted, it keeps the grant until it presents a byte with req_last, or until a stall watchdog aborts the frame.
- Output is a registered valid/ready stage that feeds the SPI TX byte buffer.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, consecutive granted-but-idle cycles before a frame is aborted (>=2).
- CNT_W, 7, width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- sysClk  in  1  system clock, rising edge.
- sysRst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_byte  in  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of the frame; qualified by req_valid.
- req_ready  out  NUM_REQ  byte accepted when req_valid[i]&req_ready[i].
- grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- byte_out  out  8  byte to the SPI TX buffer.
- byte_out_valid  out  1  byte_out holds a byte.
- byte_out_ready  in  1  SPI TX buffer accepts this cycle.
- frame_done  out  1  one-cycle pulse when a req_last byte is accepted.
- frame_abort  out  1  one-cycle pulse when the watchdog aborts a frame.

Behaviour:
- Reset (async assert, sync release to next edge) clears:
  - state=IDLE, grant=0, req_ready=0;
  - byte_out=8'h00, byte_out_valid=0;
  - frame_done=0, frame_abort=0, watchdog=0;
  - last_owner=NUM_REQ-1, so requester 0 wins first.
- Reset mid-frame drops any partially sent frame and the byte held in the output register. Requesters must restart their frames.
- State IDLE:
  - If any req_valid, pick the first i with req_valid set, searching last_owner+1, +2, ... with wrap.
  - The grant register is loaded on that edge and state becomes STREAM.
  - Arbitration latency is one cycle; no byte is accepted in IDLE.
- State STREAM, owner g:
  - req_ready[g] = ~byte_out_valid | byte_out_ready (combinational); all other req_ready bits = 0.
  - On accept: byte_out <= req_byte[g], byte_out_valid <= 1, watchdog <= 0.
  - Accept with req_last[g]: frame_done pulses next cycle, last_owner <= g, grant <= 0, state <= IDLE.
  - Back-to-back frames from the same requester are allowed if no other requester is valid. Minimum gap is one idle cycle, for arbitration.
- Output stage:
  - byte_out_valid clears on byte_out_ready, unless a new byte is accepted the same cycle; full throughput is one byte per cycle.
  - byte_out is stable while byte_out_valid=1 and byte_out_ready=0.
- Watchdog:
  - In STREAM, increments each cycle req_valid[g]=0.
  - Does not count while the owner is valid but back-pressured.
  - Saturates; it is never wrapped.
  - On reaching TIMEOUT_CYCLES-1 with req_valid[g] still 0: frame_abort pulses next cycle, last_owner <= g, grant <= 0, state <= IDLE.
  - A byte already in the output register still drains.
  - A valid byte arriving in the same cycle as expiry takes precedence: it is accepted and the abort is cancelled.
- The grant never changes mid-frame. A requester deasserting req_valid mid-frame does not lose the grant until the watchdog expires.
- frame_done and frame_abort are mutually exclusive.

Optional Feature:
- Macro: SPI_TX_ARB_PRIO0_EN.
- Defined: requester 0 (register-read path) has strict priority in IDLE. If req_valid[0]=1 it wins regardless of last_owner; the others rotate round-robin among themselves. Frames are still atomic, so requester 0 never preempts an active frame.
- Undefined: pure round-robin across all requesters as above.

Test Plan:
- Single frame, req0 sends 8'hA1,8'hB2,8'hC3,8'hD4 (last on D4), byte_out_ready=1 -> grant=001 one cycle after req_valid, byte_out sequence A1,B2,C3,D4 on consecutive cycles, frame_done one pulse, grant=000.
- All three requesters hold 2-byte frames continuously -> frames issued in order req0,req1,req2,req0; no byte interleaving between frames.
- Back-pressure: byte_out_ready=0 for 5 cycles mid-frame -> byte_out holds its value, req_ready[g]=0, watchdog stays 0, no abort; the sequence resumes intact.
- Stall: req1 granted, sends 8'h55, then req_valid[1]=0 for 64 cycles -> frame_abort pulses once; next grant goes to req2 if valid, else the next valid requester after req1.
- sysRst asserted mid-frame with byte_out_valid=1 -> byte_out_valid=0, grant=000 immediately (asynchronous); after release, requester 0 wins first.
- With SPI_TX_ARB_PRIO0_EN, req0 and req2 valid after req0's frame ends -> req0 is granted again; without the macro, req2 is granted.
